// File: rtl/mc_cpu.sv
// mc_cpu: multi-cycle MIPS-subset core with one unified memory port (req/ready handshake).
// A single FSM sequences fetch, decode, execute, memory and write-back steps. One shared ALU
// serves PC increment, branch target, address generation and arithmetic.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        asynchronous active-low reset
//   mem_req    memory transaction request (held until mem_ready)
//   mem_we     1 = write (sw), 0 = read (fetch / lw)
//   mem_addr   word-aligned byte address, upper bits dropped
//   mem_wdata  store data
//   mem_rdata  read data, valid while mem_ready=1
//   mem_ready  transaction completes at posedge where mem_req & mem_ready
//   dbg_sel    register index for debug read
//   dbg_data   GPR[dbg_sel], combinational
//   pc_out     current PC
//   retire     1-cycle pulse in the last cycle of each completed instruction
//   halted     sticky error flag (illegal opcode/funct, misaligned lw/sw)
module mc_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_AW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  input  logic [4:0]        dbg_sel,
  output logic [31:0]       dbg_data,
  output logic [31:0]       pc_out,
  output logic              retire,
  output logic              halted
);

  typedef enum logic [3:0] {
    StRst, StFetch, StDecode, StExec, StMrd, StMwr, StRwb, StIwb, StLwb, StHalt
  } state_e;

  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_e;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] gpr_q [32];

  logic        gpr_we;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;

  // Instruction fields
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sext_imm, br_off;
  logic [25:0] imm26;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm26    = ir_q[25:0];
  assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
  assign br_off   = {sext_imm[29:0], 2'b00};

  logic op_legal;
  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OpRType: op_legal = (funct == FnAdd) || (funct == FnSub) || (funct == FnAnd) ||
                          (funct == FnOr)  || (funct == FnSlt);
      OpJ, OpBeq, OpBne, OpAddi, OpLw, OpSw: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  // Shared ALU: operand/op selection depends on the current step.
  logic [31:0] alu_a, alu_b, alu_y;
  alu_op_e     alu_op;

  always_comb begin
    alu_a  = a_q;
    alu_b  = sext_imm;
    alu_op = AluAdd;
    case (state_q)
      StFetch: begin
        alu_a = pc_q;
        alu_b = 32'd4;
      end
      StDecode: begin
        alu_a = pc_q;
        alu_b = br_off;
      end
      StExec: begin
        if (opcode == OpRType) begin
          alu_b = b_q;
          case (funct)
            FnSub:   alu_op = AluSub;
            FnAnd:   alu_op = AluAnd;
            FnOr:    alu_op = AluOr;
            FnSlt:   alu_op = AluSlt;
            default: alu_op = AluAdd;
          endcase
        end else if (opcode == OpBeq || opcode == OpBne) begin
          alu_b  = b_q;
          alu_op = AluSub;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (alu_op)
      AluSub:  alu_y = alu_a - alu_b;
      AluAnd:  alu_y = alu_a & alu_b;
      AluOr:   alu_y = alu_a | alu_b;
      AluSlt:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = alu_a + alu_b;
    endcase
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    mdr_d     = mdr_q;
    gpr_we    = 1'b0;
    gpr_waddr = rd;
    gpr_wdata = alu_out_q;
    retire    = 1'b0;
    case (state_q)
      StRst: state_d = StFetch;
      StFetch: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = alu_y;
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d       = gpr_q[rs];
        b_d       = gpr_q[rt];
        alu_out_d = alu_y;
        state_d   = op_legal ? StExec : StHalt;
      end
      StExec: begin
        case (opcode)
          OpRType: begin
            alu_out_d = alu_y;
            state_d   = StRwb;
          end
          OpAddi: begin
            alu_out_d = alu_y;
            state_d   = StIwb;
          end
          OpLw, OpSw: begin
            alu_out_d = alu_y;
            if (alu_y[1:0] != 2'b00) state_d = StHalt;
            else                     state_d = (opcode == OpLw) ? StMrd : StMwr;
          end
          OpBeq, OpBne: begin
            // alu_y is A-B, so zero means equal
            if ((alu_y == 32'd0) == (opcode == OpBeq)) pc_d = alu_out_q;
            retire  = 1'b1;
            state_d = StFetch;
          end
          OpJ: begin
            pc_d    = {pc_q[31:28], imm26, 2'b00};
            retire  = 1'b1;
            state_d = StFetch;
          end
          default: state_d = StHalt;
        endcase
      end
      StMrd: begin
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = StLwb;
        end
      end
      StMwr: begin
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StRwb: begin
        gpr_we  = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StIwb: begin
        gpr_we    = 1'b1;
        gpr_waddr = rt;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StLwb: begin
        gpr_we    = 1'b1;
        gpr_waddr = rt;
        gpr_wdata = mdr_q;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StRst;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
    end
  end

  // GPR[0] is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
    end else if (gpr_we && gpr_waddr != 5'd0) begin
      gpr_q[gpr_waddr] <= gpr_wdata;
    end
  end

  // Memory port driven purely from registered state, so it is stable while waiting.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      StFetch: begin
        mem_req  = 1'b1;
        mem_addr = pc_q[MEM_AW-1:0];
      end
      StMrd: begin
        mem_req  = 1'b1;
        mem_addr = alu_out_q[MEM_AW-1:0];
      end
      StMwr: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = alu_out_q[MEM_AW-1:0];
        mem_wdata = b_q;
      end
      default: ;
    endcase
  end

  assign dbg_data = (dbg_sel == 5'd0) ? 32'd0 : gpr_q[dbg_sel];
  assign pc_out   = pc_q;
  assign halted   = (state_q == StHalt);

endmodule
